uart_rx_deframer: RTL



---
 rtl/uart_rx_deframer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
//   Recovers start / DATA_WIDTH data bits (LSB first) / one stop bit frames
//   from an asynchronous serial line. Each byte goes out through a one-entry
//   valid/ready register.
// Ports:
//   clk, rst_n           system clock, async active-low reset
//   serial_in            raw serial line (idles high)
//   rx_data, rx_valid    received byte and its valid flag
//   rx_ready             consumer accept
//   frame_error          1-cycle pulse: stop bit sampled low
//   overrun              1-cycle pulse: completed byte dropped (rx_valid held)
//   rx_busy              state != IDLE
//   debug_state          registered copy of the state register
module uart_rx_deframer #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_COUNT = CLK_FREQ / BAUD_RATE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_error,
  output logic                  overrun,
  output logic                  rx_busy,
  output logic [2:0]            debug_state
);

  localparam int HALF = BAUD_COUNT / 2;
  localparam int BCW  = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_sync1;
  logic                  r_rxs;
  logic                  r_rxs_d;
  logic [31:0]           r_cnt;
  logic [BCW-1:0]        r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;

  assign rx_busy = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b1;
      r_rxs       <= 1'b1;
      r_rxs_d     <= 1'b1;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      debug_state <= 3'd0;
    end else begin
      r_sync1     <= serial_in;
      r_rxs       <= r_sync1;
      r_rxs_d     <= r_rxs;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      debug_state <= r_state;

      // Plain consume; a delivery on the same edge overrides this below.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!r_rxs && r_rxs_d) r_state <= START;
        end
        START: begin
          if (r_cnt == 32'(HALF - 1)) begin
            r_cnt <= '0;
            if (!r_rxs) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end else begin
              r_state <= IDLE;  // false start (glitch)
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        DATA: begin
          if (r_cnt == 32'(BAUD_COUNT - 1)) begin
            r_cnt     <= '0;
            // Shift in from the top: after DATA_WIDTH samples the first bit sits at bit 0.
            r_shift   <= {r_rxs, r_shift[DATA_WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BCW'(DATA_WIDTH - 1)) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        STOP: begin
          if (r_cnt == 32'(BAUD_COUNT - 1)) begin
            r_cnt <= '0;
            if (r_rxs) begin
              r_state <= IDLE;
              if (!rx_valid || rx_ready) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_error <= 1'b1;
              r_state     <= WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        WAIT_IDLE: begin
          // A held-low (break) line must not look like a string of start bits.
          r_cnt <= '0;
          if (r_rxs) r_state <= IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
